bmp_gray_stream: RTL

//  Parametrised BMP colour-to-grayscale converter. Copies the BMP header unchanged,

---
 rtl/bmp_gray_stream.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/bmp_gray_stream.sv
// BMP colour-to-grayscale streamer: copies the header, then rewrites each pixel as weighted gray.
// Optional BMP_GRAY_THRESH_EN adds a thresh port and binarizes the gray channels.
module bmp_gray_stream #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 20,
    parameter int CHANNELS = 3,
    parameter int HDR_SIZE = 54,
    parameter int PIXELS   = 65536,
    parameter int WB       = 30,
    parameter int WG       = 150,
    parameter int WR       = 76,
    parameter int SHIFT    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              rom_ren,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_d,
    output logic              busy,
    output logic              done
`ifdef BMP_GRAY_THRESH_EN
    ,
    input  logic [DATA_W-1:0] thresh
`endif
);

    localparam int ACC_W = DATA_W + 12;
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(HDR_SIZE + PIXELS * CHANNELS - 1);
    localparam logic [ADDR_W-1:0] HDR_LAST = ADDR_W'(HDR_SIZE - 1);
    localparam logic [1:0]        K_LAST   = 2'(CHANNELS - 1);
    localparam logic [ACC_W-1:0]  MAXV     = ACC_W'((1 << DATA_W) - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR_RD,
        HDR_WR,
        PIX_RD,
        PIX_CALC,
        PIX_WR,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [ADDR_W-1:0] wr_q, wr_d;
    logic [1:0]        k_q, k_d;
    logic [DATA_W-1:0] gray_q, gray_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] buf_q [4];

    logic [DATA_W-1:0] ch2;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  shd;
    logic [DATA_W-1:0] sat;
    logic [DATA_W-1:0] gray_new;

    // Address counters saturate at the last frame byte instead of wrapping
    function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] a);
        return (a == LAST_A) ? a : a + ADDR_W'(1);
    endfunction

    // With three channels the red byte is still on rom_q during PIX_CALC
    assign ch2 = (CHANNELS == 3) ? rom_q : buf_q[2];
    assign acc = ACC_W'(buf_q[0]) * ACC_W'(WB)
               + ACC_W'(buf_q[1]) * ACC_W'(WG)
               + ACC_W'(ch2) * ACC_W'(WR);
    assign shd = acc >> SHIFT;
    assign sat = (shd > MAXV) ? '1 : shd[DATA_W-1:0];
`ifdef BMP_GRAY_THRESH_EN
    assign gray_new = (sat >= thresh) ? '1 : '0;
`else
    assign gray_new = sat;
`endif

    // State, counters, gray result and done flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rd_q    <= '0;
            wr_q    <= '0;
            k_q     <= '0;
            gray_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            k_q     <= k_d;
            gray_q  <= gray_d;
            done_q  <= done_d;
        end
    end

    // Pixel bytes land one cycle after their read; the last one during PIX_CALC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                buf_q[i] <= '0;
            end
        end else if (state_q == PIX_RD && k_q != 2'd0) begin
            buf_q[k_q - 2'd1] <= rom_q;
        end else if (state_q == PIX_CALC) begin
            buf_q[K_LAST] <= rom_q;
        end
    end

    // Next-state logic and memory strobes
    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        k_d      = k_q;
        gray_d   = gray_q;
        done_d   = done_q;
        rom_ren  = 1'b0;
        ram_wen  = 1'b0;
        rom_addr = rd_q;
        ram_addr = wr_q;
        ram_d    = '0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = HDR_RD;
                    rd_d    = '0;
                    wr_d    = '0;
                    k_d     = '0;
                    done_d  = 1'b0;
                end
            end
            HDR_RD: begin
                rom_ren = 1'b1;
                rd_d    = inc(rd_q);
                state_d = HDR_WR;
            end
            HDR_WR: begin
                ram_wen = 1'b1;
                ram_d   = rom_q;
                wr_d    = inc(wr_q);
                state_d = (wr_q == HDR_LAST) ? PIX_RD : HDR_RD;
            end
            PIX_RD: begin
                rom_ren = 1'b1;
                rd_d    = inc(rd_q);
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = PIX_CALC;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            PIX_CALC: begin
                gray_d  = gray_new;
                state_d = PIX_WR;
            end
            PIX_WR: begin
                ram_wen = 1'b1;
                ram_d   = (k_q == 2'd3) ? buf_q[3] : gray_q;
                wr_d    = inc(wr_q);
                if (k_q == K_LAST) begin
                    k_d = '0;
                    if (wr_q == LAST_A) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = PIX_RD;
                    end
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE) && (state_q != DONE);
    assign done = done_q;

endmodule
